// File: rtl/mac_array_seq.sv
// mac_array_seq: sequencer for an N x N systolic array of 3-stage MAC PEs.
// A job clears the accumulators, feeds k_len operand slices, flushes the
// array skew, then drains the N result rows one per accepted handshake.
// Optional build macro MAC_ARRAY_SEQ_PERF_EN adds saturating busy/stall
// cycle counters (perf_busy_cyc, perf_stall_cyc).
//
// Handshake: a row transfer happens on a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_valid and
// out_row hold their values. out_valid never waits on out_ready.
module mac_array_seq #(
    parameter int N     = 4,
    parameter int K_MAX = 256,
    parameter int KW    = $clog2(K_MAX + 1),
    parameter int IW    = (K_MAX > 1) ? $clog2(K_MAX) : 1,
    parameter int RW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    output logic          busy,
    output logic          done,
    output logic          mac_clr,
    output logic          feed_en,
    output logic [IW-1:0] feed_k,
    output logic          load_en,
    output logic          mult_en,
    output logic          acc_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_row,
`ifdef MAC_ARRAY_SEQ_PERF_EN
    output logic [31:0]   perf_busy_cyc,
    output logic [31:0]   perf_stall_cyc,
`endif
    output logic [2:0]    dbg_state
);

    // Flush lasts 2N cycles; counter spans 0..2N-1.
    localparam int FW = $clog2(2 * N);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 1);
    localparam logic [KW-1:0] K_SAT      = KW'(K_MAX);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic [IW-1:0] feed_k_q, feed_k_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [RW-1:0] row_q, row_d;

    logic busy_q, done_q, mac_clr_q, feed_en_q, load_en_q;
    logic mult_en_q, acc_en_q, out_valid_q;
    logic load_en_d;

    // Next-state and counter update for the job sequence.
    always_comb begin
        state_d  = state_q;
        k_len_d  = k_len_q;
        feed_k_d = feed_k_q;
        flush_d  = flush_q;
        row_d    = row_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    k_len_d = (k_len > K_SAT) ? K_SAT : k_len;
                end
            end
            S_CLEAR: begin
                feed_k_d = '0;
                flush_d  = '0;
                state_d  = (k_len_q != '0) ? S_FEED : S_FLUSH;
            end
            S_FEED: begin
                if ((32'(feed_k_q) + 32'd1) == 32'(k_len_q)) begin
                    // feed_k keeps the last index until the next job's CLEAR.
                    state_d = S_FLUSH;
                    flush_d = '0;
                end else begin
                    feed_k_d = feed_k_q + IW'(1);
                end
            end
            S_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = S_DRAIN;
                    row_d   = '0;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (row_q == ROW_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operands load during FEED and while the skew propagates, except the
    // last two flush cycles where only the mult/acc tail is still running.
    always_comb begin
        load_en_d = (state_d == S_FEED) ||
                    ((state_d == S_FLUSH) && ((32'(flush_d) + 32'd2) < 32'(2 * N)));
    end

    // State, counters and registered outputs; outputs are decoded from the
    // next state so they are glitch-free and aligned with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            feed_k_q    <= '0;
            flush_q     <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mac_clr_q   <= 1'b0;
            feed_en_q   <= 1'b0;
            load_en_q   <= 1'b0;
            mult_en_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            feed_k_q    <= feed_k_d;
            flush_q     <= flush_d;
            row_q       <= row_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            mac_clr_q   <= (state_d == S_CLEAR);
            feed_en_q   <= (state_d == S_FEED);
            load_en_q   <= load_en_d;
            // Stage enables follow load_en down the PE pipeline, ungated.
            mult_en_q   <= load_en_q;
            acc_en_q    <= mult_en_q;
            out_valid_q <= (state_d == S_DRAIN);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mac_clr   = mac_clr_q;
    assign feed_en   = feed_en_q;
    assign feed_k    = feed_k_q;
    assign load_en   = load_en_q;
    assign mult_en   = mult_en_q;
    assign acc_en    = acc_en_q;
    assign out_valid = out_valid_q;
    assign out_row   = row_q;
    assign dbg_state = state_q;

`ifdef MAC_ARRAY_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;

    // Saturating activity counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_q && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (out_valid_q && !out_ready && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy_cyc  = perf_busy_q;
    assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: doc/mac_array_seq.md
Name: mac_array_seq

Overview:
- Sequencer for an N x N systolic array of mac PEs, which computes a matrix product.
- Accepts a job of depth k_len and clears the accumulators.
- Drives the operand-feed index and the per-stage enables (load/mult/acc), aligned to the 3-stage PE pipeline.
- Flushes the array skew, then drains the N result rows through a valid/ready handshake.
- Sits between the job/command interface and the array wrapper plus its operand buffers.

Parameters:
- N, 4: array dimension, rows = cols = N; N >= 1.
- K_MAX, 256: maximum inner dimension per job.
- KW, $clog2(K_MAX+1): width of k_len.
- IW, $clog2(K_MAX) (min 1): width of feed_k.
- RW, $clog2(N) (min 1): width of out_row.

Ports:
- clk  in  1  Clock, rising edge.
- reset  in  1  Synchronous, active-high reset.
- start  in  1  Job request; sampled only in IDLE.
- k_len  in  KW  Inner dimension; captured with start.
- busy  out  1  High whenever state != IDLE.
- done  out  1  One-cycle pulse at job completion.
- mac_clr  out  1  Accumulator clear to all PEs (wrapper adapts polarity).
- feed_en  out  1  Operand buffers present element feed_k on the array edges; edges inject 0 when low.
- feed_k  out  IW  Inner-dimension index being fed.
- load_en  out  1  PE operand-register enable.
- mult_en  out  1  PE multiplier enable.
- acc_en  out  1  PE accumulator enable.
- out_valid  out  1  Result row out_row is available.
- out_ready  in  1  Consumer accepts the row.
- out_row  out  RW  Result row index being drained.

Behaviour:
- Reset: state=IDLE; all outputs 0, including the mult_en/acc_en delay regs and all counters. Reset mid-job aborts immediately. PE contents are untouched; the next job's CLEAR handles them.
- IDLE:
  - start=1: latch k_len, go to CLEAR. busy rises on the next cycle.
  - start while busy: ignored, not queued.
- CLEAR: exactly 1 cycle, mac_clr=1. Next state is FEED if k_len_q != 0, otherwise FLUSH.
- FEED: k_len_q cycles.
  - feed_en=1 and load_en=1.
  - feed_k counts 0..k_len_q-1, +1 per cycle.
  - Leave after feed_k == k_len_q-1.
- FLUSH: exactly 2N cycles, f = 0..2N-1.
  - feed_en=0.
  - load_en=1 for f < 2N-2 (skew propagation), 0 for the last 2 cycles.
- Enable pipeline:
  - mult_en(t) = load_en(t-1).
  - acc_en(t) = mult_en(t-1).
  - Never gated by state, so the tail completes inside FLUSH.
  - The last acc_en occurs at f = 2N-1.
- k_len_q=0: CLEAR then FLUSH with no feed. Results are zeros; the job still drains.
- DRAIN:
  - out_valid=1; out_row=r, starting at r=0.
  - On out_valid & out_ready: r+1.
  - out_valid and out_row stay stable while out_ready=0; no timeout.
  - Acceptance of r=N-1 goes to DONE.
- DONE: 1 cycle, done=1, busy=1. Next state IDLE. start is not accepted in DONE; it is accepted from the following cycle.
- Total latency with out_ready held 1: start to done = 1 + 1 + k_len + 2N + N cycles (done on cycle k_len + 3N + 2 counting the start cycle as 0).
- k_len > K_MAX: saturate k_len_q to K_MAX.
- Widths:
  - PE accumulators are 4*WIDTH; the sequencer guarantees at most K_MAX accumulations per clear.
  - The requirement is K_MAX <= 2^(2*WIDTH).
- mac_clr, feed_en and load_en are registered outputs (glitch-free).

Optional Feature:
- Macro: MAC_ARRAY_SEQ_PERF_EN.
- Defined: adds outputs perf_busy_cyc [31:0] and perf_stall_cyc [31:0].
  - perf_busy_cyc increments every cycle busy=1.
  - perf_stall_cyc increments every cycle out_valid & ~out_ready.
  - Both saturate at all-ones, clear on reset, and are never cleared by start.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- N=4, k_len=8, out_ready=1, start at cycle 0:
  - mac_clr at cycle 1.
  - feed_en cycles 2-9 with feed_k 0..7.
  - load_en cycles 2-15; mult_en 3-16; acc_en 4-17.
  - out_valid 18-21 with out_row 0..3.
  - done at cycle 22; busy 1-22.
- Same job, out_ready toggled 1,0,0,1,...:
  - out_row holds its value during low cycles; no row is skipped or duplicated.
  - done arrives exactly 2 cycles per stall pair later.
  - PERF build: perf_stall_cyc equals the number of stalled cycles.
- k_len=0, N=4:
  - CLEAR, then FLUSH with load_en 6 cycles and feed_en never 1.
  - 4 rows drained; done at cycle 14.
- start pulsed during FEED and in the DONE cycle: ignored. A start the cycle after done begins a new job with mac_clr 1 cycle later.
- reset asserted mid-FLUSH (and with out_valid=1 mid-DRAIN): next cycle all outputs are 0 and state is IDLE. A subsequent start runs a clean job matching the first scenario's timing.
- k_len=K_MAX+5 (K_MAX=256): feed_en held exactly 256 cycles, feed_k wraps to 0 only at the next job.
